// File: rtl/nn_pkg.sv
// nn_pkg: shared constants, bank-select codes and FSM states for the NN host sequencer
package nn_pkg;
  localparam int FP_W = 32;
  localparam int LEN = 9;
  localparam logic [1:0] SEL_U = 2'd0;
  localparam logic [1:0] SEL_W = 2'd1;
  localparam logic [1:0] SEL_V = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_DONE} state_e;
endpackage

// File: rtl/nn_operand_bank.sv
// nn_operand_bank: 4x9 operand register file, one write port, four parallel reads at one index
module nn_operand_bank
  import nn_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [1:0]      sel,
  input  logic [3:0]      widx,
  input  logic [FP_W-1:0] wdata,
  input  logic [3:0]      ridx,
  output logic [FP_W-1:0] rd_u,
  output logic [FP_W-1:0] rd_w,
  output logic [FP_W-1:0] rd_v,
  output logic [FP_W-1:0] rd_x
);
  logic [FP_W-1:0] mem_q [4][LEN];
  logic [FP_W-1:0] mem_d [4][LEN];
  logic            rok;
  // apply the write, dropping out-of-range indices
  always_comb begin
    mem_d = mem_q;
    if (we && widx < 4'(LEN)) mem_d[sel][widx] = wdata;
  end
  // storage; reset clears every bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
  // reads see a same-cycle write so a write issued alongside start reaches beat 0
  assign rok  = ridx < 4'(LEN);
  assign rd_u = rok ? mem_d[SEL_U][ridx] : '0;
  assign rd_w = rok ? mem_d[SEL_W][ridx] : '0;
  assign rd_v = rok ? mem_d[SEL_V][ridx] : '0;
  assign rd_x = rok ? mem_d[SEL_X][ridx] : '0;
endmodule

// File: rtl/nn_host_seq.sv
// nn_host_seq: bursts stored operands into the NN core, captures its result burst and replays it as a stream
module nn_host_seq
  import nn_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  input  logic [1:0]      cfg_sel,
  input  logic [3:0]      cfg_idx,
  input  logic [FP_W-1:0] cfg_data,
  input  logic            start,
  output logic            busy,
  output logic            err_timeout,
  output logic            err_short,
  output logic            in_valid_u,
  output logic            in_valid_w,
  output logic            in_valid_v,
  output logic            in_valid_x,
  output logic [FP_W-1:0] weight_u,
  output logic [FP_W-1:0] weight_w,
  output logic [FP_W-1:0] weight_v,
  output logic [FP_W-1:0] data_x,
  input  logic            out_valid,
  input  logic [FP_W-1:0] out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [FP_W-1:0] res_data,
  output logic            res_last
);
  state_e          state_q, state_d;
  logic [3:0]      beat_q, beat_d, cnt_q, cnt_d, rd_q, rd_d, ridx;
  logic [7:0]      to_q, to_d;
  logic [FP_W-1:0] res_q [LEN];
  logic [FP_W-1:0] res_d [LEN];
  logic            et_q, et_d, es_q, es_d, iv_q, iv_d;
  logic [FP_W-1:0] u_q, u_d, w_q, w_d, v_q, v_d, x_q, x_d;
  logic [FP_W-1:0] b_u, b_w, b_v, b_x;
  logic            bank_we;

  assign bank_we = cfg_valid && state_q == S_IDLE;
  assign ridx    = state_q == S_SEND ? beat_q : '0;

  nn_operand_bank u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .sel   (cfg_sel),
    .widx  (cfg_idx),
    .wdata (cfg_data),
    .ridx  (ridx),
    .rd_u  (b_u),
    .rd_w  (b_w),
    .rd_v  (b_v),
    .rd_x  (b_x)
  );

  // sequencing: operand burst, result capture with abort paths, then stream replay
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    to_d    = to_q;
    res_d   = res_q;
    et_d    = et_q;
    es_d    = es_q;
    iv_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SEND;
        res_d   = '{default: '0};
        et_d    = 1'b0;
        es_d    = 1'b0;
        iv_d    = 1'b1;
        beat_d  = 4'd1;
        cnt_d   = '0;
        rd_d    = '0;
        to_d    = '0;
      end
      S_SEND: begin
        iv_d   = 1'b1;
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'(LEN - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (out_valid) begin
          res_d[0] = out;
          cnt_d    = 4'd1;
          state_d  = S_COLLECT;
        end else if (to_q == 8'(TIMEOUT - 1)) begin
          et_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q == 8'hFF ? to_q : to_q + 8'd1;
        end
      end
      S_COLLECT: begin
        if (cnt_q == 4'(LEN)) begin
          state_d = S_DONE;
        end else if (out_valid) begin
          res_d[cnt_q] = out;
          cnt_d        = cnt_q + 4'd1;
        end else begin
          es_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: if (res_ready) begin
        rd_d = rd_q == 4'(LEN - 1) ? '0 : rd_q + 4'd1;
        state_d = rd_q == 4'(LEN - 1) ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    u_d = iv_d ? b_u : '0;
    w_d = iv_d ? b_w : '0;
    v_d = iv_d ? b_v : '0;
    x_d = iv_d ? b_x : '0;
  end

  // state, counters, result buffer and registered core-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      to_q    <= '0;
      res_q   <= '{default: '0};
      et_q    <= 1'b0;
      es_q    <= 1'b0;
      iv_q    <= 1'b0;
      u_q     <= '0;
      w_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      to_q    <= to_d;
      res_q   <= res_d;
      et_q    <= et_d;
      es_q    <= es_d;
      iv_q    <= iv_d;
      u_q     <= u_d;
      w_q     <= w_d;
      v_q     <= v_d;
      x_q     <= x_d;
    end
  end

  assign busy        = state_q != S_IDLE;
  assign err_timeout = et_q;
  assign err_short   = es_q;
  assign in_valid_u  = iv_q;
  assign in_valid_w  = iv_q;
  assign in_valid_v  = iv_q;
  assign in_valid_x  = iv_q;
  assign weight_u    = u_q;
  assign weight_w    = w_q;
  assign weight_v    = v_q;
  assign data_x      = x_q;
  assign res_valid   = state_q == S_DONE;
  assign res_data    = res_valid ? res_q[rd_q] : '0;
  assign res_last    = res_valid && rd_q == 4'(LEN - 1);
endmodule

// File: tb/tb_nn_host_seq.sv
// tb_nn_host_seq: table-driven and randomized runs checked against a bank/result model
module tb_nn_host_seq;
  import nn_pkg::*;

  logic        clk = 0, rst_n = 0, cfg_valid = 0, start = 0, out_valid = 0, res_ready = 0;
  logic [1:0]  cfg_sel = 0;
  logic [3:0]  cfg_idx = 0;
  logic [31:0] cfg_data = 0, out = 0;
  logic        busy, err_timeout, err_short, in_valid_u, in_valid_w, in_valid_v, in_valid_x;
  logic        res_valid, res_last;
  logic [31:0] weight_u, weight_w, weight_v, data_x, res_data;

  int total = 0, bad = 0;
  logic [31:0] bank_m [4][9];
  logic [31:0] core_w [9];

  typedef struct {
    int n; int dly; int rmode; bit wr0; bit poke;
    bit exp_to; bit exp_sh;
  } vec_t;

  always #5 clk = ~clk;

  nn_host_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .start(start), .busy(busy), .err_timeout(err_timeout),
    .err_short(err_short), .in_valid_u(in_valid_u), .in_valid_w(in_valid_w),
    .in_valid_v(in_valid_v), .in_valid_x(in_valid_x), .weight_u(weight_u),
    .weight_w(weight_w), .weight_v(weight_v), .data_x(data_x), .out_valid(out_valid),
    .out(out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // config write while idle; the model drops out-of-range indices
  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] idx, input logic [31:0] d);
    cfg_valid = 1; cfg_sel = sel; cfg_idx = idx; cfg_data = d;
    @(negedge clk);
    cfg_valid = 0;
    if (idx < 9) bank_m[sel][idx] = d;
  endtask

  task automatic run(input vec_t v, input logic [31:0] wd);
    logic [31:0] exp_res [9];
    logic [31:0] snap [4][9];
    int i, guard;
    bit r;
    start = 1;
    if (v.wr0) begin
      cfg_valid = 1; cfg_sel = SEL_X; cfg_idx = 0; cfg_data = wd;
      bank_m[3][0] = wd;
    end
    snap = bank_m;
    for (int k = 0; k < 9; k++) exp_res[k] = k < v.n ? core_w[k] : 32'h0;
    @(negedge clk);
    start = 0; cfg_valid = 0;
    check("busy_after_start", busy, 1);
    check("errs_cleared", {err_timeout, err_short}, 0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("in_valid_beat%0d", k), {in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 4'hF);
      check($sformatf("u_beat%0d", k), weight_u, snap[0][k]);
      check($sformatf("w_beat%0d", k), weight_w, snap[1][k]);
      check($sformatf("v_beat%0d", k), weight_v, snap[2][k]);
      check($sformatf("x_beat%0d", k), data_x, snap[3][k]);
      @(negedge clk);
    end
    check("in_valid_after_burst", {in_valid_u, in_valid_w, in_valid_v, in_valid_x}, 0);
    check("ops_zero_after_burst", weight_u | weight_w | weight_v | data_x, 0);
    if (v.n == 0) begin
      repeat (253) @(negedge clk);
      check("timeout_not_early", err_timeout, 0);
      @(negedge clk);
      check("timeout_flag", err_timeout, 1);
    end else begin
      repeat (v.dly) @(negedge clk);
      for (int k = 0; k < v.n; k++) begin
        out_valid = 1; out = core_w[k];
        @(negedge clk);
      end
      out_valid = 0; out = $urandom;
      if (v.n == 9) begin
        check("res_valid_not_early", res_valid, 0);
        @(negedge clk);
      end else begin
        check("short_not_early", err_short, 0);
        @(negedge clk);
        check("short_flag", err_short, 1);
      end
    end
    i = 0; guard = 0;
    while (i < 9 && guard < 60) begin
      check("res_valid", res_valid, 1);
      check($sformatf("res_data%0d", i), res_data, exp_res[i]);
      check($sformatf("res_last%0d", i), res_last, i == 8);
      r = v.rmode == 0 ? 1'b1 : v.rmode == 1 ? (guard % 2 == 0) : 1'($urandom % 2);
      if (v.poke && guard == 1) begin
        start = 1; cfg_valid = 1; cfg_sel = SEL_U; cfg_idx = 0; cfg_data = 32'hDEADBEEF;
      end
      res_ready = r;
      @(negedge clk);
      start = 0; cfg_valid = 0;
      if (r) i++;
      guard++;
    end
    res_ready = 0;
    if (i < 9) check("drain_budget", i, 9);
    check("busy_end", busy, 0);
    check("res_valid_end", res_valid, 0);
    check("err_timeout_sticky", err_timeout, v.exp_to);
    check("err_short_sticky", err_short, v.exp_sh);
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{n: 9, dly: 30, rmode: 0, wr0: 0, poke: 0, exp_to: 0, exp_sh: 0};
    tbl[1] = '{n: 0, dly: 0,  rmode: 0, wr0: 0, poke: 0, exp_to: 1, exp_sh: 0};
    tbl[2] = '{n: 5, dly: 3,  rmode: 0, wr0: 0, poke: 0, exp_to: 0, exp_sh: 1};
    tbl[3] = '{n: 9, dly: 2,  rmode: 1, wr0: 0, poke: 1, exp_to: 0, exp_sh: 0};
    tbl[4] = '{n: 9, dly: 0,  rmode: 0, wr0: 1, poke: 0, exp_to: 0, exp_sh: 0};
    tbl[5] = '{n: 1, dly: 1,  rmode: 1, wr0: 0, poke: 0, exp_to: 0, exp_sh: 1};
    tbl[6] = '{n: 8, dly: 4,  rmode: 0, wr0: 0, poke: 0, exp_to: 0, exp_sh: 1};
    for (int s = 0; s < 4; s++) for (int k = 0; k < 9; k++) bank_m[s][k] = 0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {busy, err_timeout, err_short, in_valid_u, in_valid_w, in_valid_v,
                      in_valid_x, res_valid, res_last}, 0);
    check("rst_data", weight_u | weight_w | weight_v | data_x | res_data, 0);
    rst_n = 1;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      cfg_write(SEL_U, 4'(k), 32'h3F800000);
      cfg_write(SEL_W, 4'(k), 32'h0);
      cfg_write(SEL_V, 4'(k), 32'h40000000);
      cfg_write(SEL_X, 4'(k), k);
    end
    cfg_write(SEL_U, 4'd9, 32'hBAD0BAD0);
    cfg_write(SEL_X, 4'd15, 32'hBAD1BAD1);
    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 9; k++) core_w[k] = 32'h3F000000 + k;
      run(tbl[t], 32'h12345678 + t);
      @(negedge clk);
    end
    // randomized runs
    for (int t = 0; t < 12; t++) begin
      vec_t v;
      repeat (4) cfg_write(2'($urandom), 4'($urandom_range(0, 12)), $urandom);
      for (int k = 0; k < 9; k++) core_w[k] = $urandom;
      v.n = $urandom_range(1, 9); v.dly = $urandom_range(0, 5); v.rmode = 2;
      v.wr0 = 1'($urandom % 2); v.poke = 1'($urandom % 2);
      v.exp_to = 0; v.exp_sh = v.n < 9;
      run(v, $urandom);
    end
    // reset in the middle of the operand burst
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    check("pre_reset_beat4", data_x, bank_m[3][4]);
    rst_n = 0;
    #1;
    check("midrst_ctl", {busy, err_timeout, err_short, in_valid_u, in_valid_w, in_valid_v,
                         in_valid_x, res_valid, res_last}, 0);
    @(negedge clk);
    check("midrst_data", weight_u | weight_w | weight_v | data_x | res_data, 0);
    rst_n = 1;
    for (int s = 0; s < 4; s++) for (int k = 0; k < 9; k++) bank_m[s][k] = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {busy, in_valid_u, in_valid_x}, 0);
    end
    for (int k = 0; k < 9; k++) core_w[k] = 32'hC0000000 | k;
    run(tbl[0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
